// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle on
// operand magnitudes, with sign fix-up applied on the final iteration.
// Ports:
//   clk, Reset (async, active low)
//   start, op[1:0], a, b  - launch MULTU/MULT/DIVU/DIV (accepted in IDLE only)
//   flush                 - abort an in-flight operation
//   hi_we, lo_we, wdata   - direct HI/LO writes (IDLE only)
//   busy, done, div_zero  - registered status
//   hi, lo                - result registers
module mul_div_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   wh;      // partial product upper half / remainder
    logic [WIDTH-1:0]   wl;      // multiplier bits / dividend->quotient bits
    logic [WIDTH-1:0]   wop;     // multiplicand / divisor magnitude
    logic               is_div;
    logic               neg_q;   // product or quotient must be negated
    logic               neg_r;   // remainder must be negated

    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   q_res;
    logic [WIDTH-1:0]   r_res;

    // Operand magnitudes and sign capture at acceptance
    always_comb begin
        sgn_op = SIGNED_EN && op[0];
        a_neg  = sgn_op && a[WIDTH-1];
        b_neg  = sgn_op && b[WIDTH-1];
        a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
    end

    // One iteration of each algorithm plus the signed fix-up of its result
    always_comb begin
        mul_sum  = {1'b0, wh} + (wl[0] ? {1'b0, wop} : {(WIDTH+1){1'b0}});
        mul_prod = {mul_sum, wl[WIDTH-1:1]};
        mul_res  = neg_q ? (~mul_prod + (2*WIDTH)'(1)) : mul_prod;

        div_sh   = {wh, wl[WIDTH-1]};
        div_diff = div_sh - {1'b0, wop};
        div_ok   = ~div_diff[WIDTH];
        div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_q    = {wl[WIDTH-2:0], div_ok};
        q_res    = neg_q ? (~div_q + WIDTH'(1)) : div_q;
        r_res    = neg_r ? (~div_rem + WIDTH'(1)) : div_rem;
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wh       <= '0;
            wl       <= '0;
            wop      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        if (op[1] && (b == '0)) begin
                            // Divide by zero resolves immediately, no CALC cycles
                            hi       <= a;
                            lo       <= '1;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            is_div <= op[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            wop    <= op[1] ? b_mag : a_mag;
                            wl     <= op[1] ? a_mag : b_mag;
                            wh     <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            wh <= div_rem;
                            wl <= div_q;
                        end else begin
                            wh <= mul_prod[2*WIDTH-1:WIDTH];
                            wl <= mul_prod[WIDTH-1:0];
                        end
                        cnt <= cnt + CW'(1);
                        // Last iteration commits straight into HI/LO
                        if (cnt == CW'(WIDTH-1)) begin
                            if (is_div) begin
                                hi <= r_res;
                                lo <= q_res;
                            end else begin
                                hi <= mul_res[2*WIDTH-1:WIDTH];
                                lo <= mul_res[WIDTH-1:0];
                            end
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a 32-bit signed instance and a 16-bit
// unsigned-only instance share stimulus; results are compared to a table.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    logic [15:0] a16, b16, wdata16;
    logic        busy16, done16, dz16;
    logic [15:0] hi16, lo16;

    assign a16     = a[15:0];
    assign b16     = b[15:0];
    assign wdata16 = wdata[15:0];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    mul_div_unit #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
        .clk(clk), .Reset(Reset), .start(start), .op(op), .a(a16), .b(b16),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata16),
        .busy(busy16), .done(done16), .div_zero(dz16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic [15:0] hi16;
        logic [15:0] lo16;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        int          e32, e16, bz;
        logic [31:0] h32, l32;
        logic        d32;
        logic [15:0] h16, l16;
        logic        d16;
        e32 = 0; e16 = 0; bz = 0;
        h32 = '0; l32 = '0; d32 = 1'b0; h16 = '0; l16 = '0; d16 = 1'b0;
        @(posedge clk); #1;
        op = vecs[idx].op; a = vecs[idx].a; b = vecs[idx].b; start = 1'b1;
        for (int e = 1; e <= 60 && e32 == 0; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) bz++;
            if (done16 && e16 == 0) begin
                e16 = e; h16 = hi16; l16 = lo16; d16 = dz16;
            end
            if (done) begin
                e32 = e; h32 = hi; l32 = lo; d32 = div_zero;
            end
        end
        chk($sformatf("v%0d done_edge", idx), 32'(e32), vecs[idx].dz ? 32'd1 : 32'd33);
        chk($sformatf("v%0d busy_cycles", idx), 32'(bz), vecs[idx].dz ? 32'd0 : 32'd32);
        chk($sformatf("v%0d hi", idx), h32, vecs[idx].hi);
        chk($sformatf("v%0d lo", idx), l32, vecs[idx].lo);
        chk($sformatf("v%0d div_zero", idx), 32'(d32), 32'(vecs[idx].dz));
        chk($sformatf("v%0d w16 done_edge", idx), 32'(e16), vecs[idx].dz ? 32'd1 : 32'd17);
        chk($sformatf("v%0d w16 hi", idx), 32'(h16), 32'(vecs[idx].hi16));
        chk($sformatf("v%0d w16 lo", idx), 32'(l16), 32'(vecs[idx].lo16));
        chk($sformatf("v%0d w16 div_zero", idx), 32'(d16), 32'(vecs[idx].dz));
    endtask

    initial begin
        int ndone;
        int e;
        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 16'hFFFE, 16'h0001};
        vecs[1] = '{2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 16'h0005, 16'hFFD6};
        vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 16'h0001, 16'h7FFC};
        vecs[3] = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 16'h0064, 16'hFFFF};
        vecs[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{2'b01, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0, 16'hFFF8, 16'h000F};
        vecs[6] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 16'h0007, 16'h0000};
        vecs[7] = '{2'b10, 32'h000003E8, 32'h00000007, 32'h00000006, 32'h0000008E, 1'b0, 16'h0006, 16'h008E};
        vecs[8] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 16'h0005, 16'h6780};
        vecs[9] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 16'hFFF9, 16'hFFFF};

        Reset = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(posedge clk); #1 Reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Direct HI/LO writes in IDLE
        @(posedge clk); #1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi idle", hi, 32'h0000_1234);
        chk("mtlo idle", lo, 32'h0000_1234);
        lo_we = 1'b1; wdata = 32'h0000_5678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo idle 2", lo, 32'h0000_5678);

        // Flush mid-CALC, with an ignored start and an ignored hi_we
        op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("flush busy after start", 32'(busy), 32'd1);
        for (e = 2; e <= 11; e++) begin
            @(posedge clk); #1;
            start = (e == 3);
            if (e == 3) begin op = 2'b10; a = 32'd9; b = 32'd0; end
            hi_we = (e == 5);
            wdata = 32'h0000_DEAD;
            flush = (e == 10);
        end
        chk("flush busy dropped", 32'(busy), 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("flush no done", 32'(ndone), 32'd0);
        chk("flush hi kept", hi, 32'h0000_1234);
        chk("flush lo kept", lo, 32'h0000_5678);

        // Flush together with start in IDLE: start ignored
        op = 2'b00; a = 32'd7; b = 32'd7; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("flush+start done", 32'(done), 32'd0);

        // MTLO with start in the same cycle: write lands, result overwrites
        op = 2'b00; a = 32'd2; b = 32'd3; wdata = 32'h0000_AAAA;
        lo_we = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        lo_we = 1'b0; start = 1'b0;
        chk("mtlo+start lo", lo, 32'h0000_AAAA);
        chk("mtlo+start busy", 32'(busy), 32'd1);
        e = 0;
        for (int k = 2; k <= 60 && e == 0; k++) begin
            @(posedge clk); #1;
            if (done) e = k;
        end
        chk("mtlo+start done edge", 32'(e), 32'd33);
        chk("mtlo+start lo result", lo, 32'd6);
        chk("mtlo+start hi result", hi, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of CALC
        op = 2'b00; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 Reset = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        @(posedge clk); #1 Reset = 1'b1;
        run_vec(0);
        run_vec(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
